onchip_mem_arbiter: RTL and testbench

//   Shares the single-port 32K x 32 on-chip RAM between two Avalon-MM requesters
//   (A: Nios data master, B: camera/R_DETECT frame-stats engine).

---
 rtl/onchip_mem_arbiter_if.sv | 51 +++++
 rtl/onchip_mem_arbiter.sv | 137 +++++++++++++
 tb/tb_onchip_mem_arbiter.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/onchip_mem_arbiter_if.sv
// Avalon-MM bundle between two requesters, the arbiter and the single-port RAM.
`timescale 1ns/1ps
interface onchip_mem_arbiter_if #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 32
);
    localparam int BE_W = DATA_W / 8;

    logic              a_read;
    logic              a_write;
    logic [ADDR_W-1:0] a_address;
    logic [BE_W-1:0]   a_byteenable;
    logic [DATA_W-1:0] a_writedata;
    logic              a_waitrequest;
    logic [DATA_W-1:0] a_readdata;
    logic              a_readdatavalid;

    logic              b_read;
    logic              b_write;
    logic [ADDR_W-1:0] b_address;
    logic [BE_W-1:0]   b_byteenable;
    logic [DATA_W-1:0] b_writedata;
    logic              b_waitrequest;
    logic [DATA_W-1:0] b_readdata;
    logic              b_readdatavalid;

    logic [ADDR_W-1:0] mem_address;
    logic [BE_W-1:0]   mem_byteenable;
    logic              mem_chipselect;
    logic              mem_write;
    logic [DATA_W-1:0] mem_writedata;
    logic [DATA_W-1:0] mem_readdata;

    modport slave (
        input  a_read, a_write, a_address, a_byteenable, a_writedata,
        input  b_read, b_write, b_address, b_byteenable, b_writedata,
        input  mem_readdata,
        output a_waitrequest, a_readdata, a_readdatavalid,
        output b_waitrequest, b_readdata, b_readdatavalid,
        output mem_address, mem_byteenable, mem_chipselect, mem_write, mem_writedata
    );

    modport master (
        output a_read, a_write, a_address, a_byteenable, a_writedata,
        output b_read, b_write, b_address, b_byteenable, b_writedata,
        output mem_readdata,
        input  a_waitrequest, a_readdata, a_readdatavalid,
        input  b_waitrequest, b_readdata, b_readdatavalid,
        input  mem_address, mem_byteenable, mem_chipselect, mem_write, mem_writedata
    );
endinterface

// File: rtl/onchip_mem_arbiter.sv
// Round-robin arbiter with bounded bursts sharing one single-port RAM between
// two Avalon-MM requesters; routes the 1-cycle read return to the right master.
`timescale 1ns/1ps
module onchip_mem_arbiter #(
    parameter int ADDR_W    = 15,
    parameter int DATA_W    = 32,
    parameter int BURST_MAX = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  freeze,
    onchip_mem_arbiter_if.slave   bus
);
    localparam int BE_W  = DATA_W / 8;
    localparam int CNT_W = $clog2(BURST_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BURST_MAX);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic {
        OWN_A = 1'b0,
        OWN_B = 1'b1
    } owner_t;

    owner_t           r_owner;
    owner_t           w_owner_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_req_a;
    logic             w_req_b;
    logic             w_gnt_a;
    logic             w_gnt_b;
    logic             w_owner_hit;
    logic             r_rdv_a;
    logic             r_rdv_b;

    assign w_req_a = bus.a_read | bus.a_write;
    assign w_req_b = bus.b_read | bus.b_write;

    // Same-cycle grant decision; reset and freeze suppress every grant.
    always_comb begin
        w_gnt_a = 1'b0;
        w_gnt_b = 1'b0;
        if (!reset_n || freeze) begin
            w_gnt_a = 1'b0;
            w_gnt_b = 1'b0;
        end else if (w_req_a && w_req_b) begin
            if (r_cnt < CNT_MAX) begin
                w_gnt_a = (r_owner == OWN_A);
                w_gnt_b = (r_owner == OWN_B);
            end else begin
                w_gnt_a = (r_owner == OWN_B);
                w_gnt_b = (r_owner == OWN_A);
            end
        end else begin
            w_gnt_a = w_req_a;
            w_gnt_b = w_req_b;
        end
    end

    assign w_owner_hit = (w_gnt_a && (r_owner == OWN_A)) || (w_gnt_b && (r_owner == OWN_B));

    // Owner/burst-count update: saturate on repeat grants, restart on hand-over.
    always_comb begin
        w_owner_nxt = r_owner;
        w_cnt_nxt   = r_cnt;
        if (freeze) begin
            w_owner_nxt = r_owner;
            w_cnt_nxt   = r_cnt;
        end else if (w_owner_hit) begin
            if (r_cnt < CNT_MAX) begin
                w_cnt_nxt = r_cnt + CNT_ONE;
            end else begin
                w_cnt_nxt = CNT_MAX;
            end
        end else if (w_gnt_a || w_gnt_b) begin
            w_owner_nxt = w_gnt_b ? OWN_B : OWN_A;
            w_cnt_nxt   = CNT_ONE;
        end else begin
            w_cnt_nxt = {CNT_W{1'b0}};
        end
    end

    // Arbitration state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_owner <= OWN_A;
            r_cnt   <= {CNT_W{1'b0}};
        end else begin
            r_owner <= w_owner_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Read-return tracking; a simultaneous write suppresses the read.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rdv_a <= 1'b0;
            r_rdv_b <= 1'b0;
        end else begin
            r_rdv_a <= w_gnt_a & bus.a_read & ~bus.a_write;
            r_rdv_b <= w_gnt_b & bus.b_read & ~bus.b_write;
        end
    end

    // RAM port mux from the granted master, zeroed when idle.
    always_comb begin
        bus.mem_address    = {ADDR_W{1'b0}};
        bus.mem_byteenable = {BE_W{1'b0}};
        bus.mem_write      = 1'b0;
        bus.mem_writedata  = {DATA_W{1'b0}};
        if (w_gnt_a) begin
            bus.mem_address    = bus.a_address;
            bus.mem_byteenable = bus.a_write ? bus.a_byteenable : {BE_W{1'b1}};
            bus.mem_write      = bus.a_write;
            bus.mem_writedata  = bus.a_writedata;
        end else if (w_gnt_b) begin
            bus.mem_address    = bus.b_address;
            bus.mem_byteenable = bus.b_write ? bus.b_byteenable : {BE_W{1'b1}};
            bus.mem_write      = bus.b_write;
            bus.mem_writedata  = bus.b_writedata;
        end else begin
            bus.mem_address    = {ADDR_W{1'b0}};
            bus.mem_byteenable = {BE_W{1'b0}};
            bus.mem_write      = 1'b0;
            bus.mem_writedata  = {DATA_W{1'b0}};
        end
    end

    assign bus.mem_chipselect  = w_gnt_a | w_gnt_b;
    assign bus.a_waitrequest   = w_req_a & ~w_gnt_a;
    assign bus.b_waitrequest   = w_req_b & ~w_gnt_b;
    assign bus.a_readdata      = bus.mem_readdata;
    assign bus.b_readdata      = bus.mem_readdata;
    assign bus.a_readdatavalid = r_rdv_a;
    assign bus.b_readdatavalid = r_rdv_b;

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// Bench for onchip_mem_arbiter: directed table, corner sequences and random traffic
// checked against a transaction-level model with its own memory image.
`timescale 1ns/1ps
module tb_onchip_mem_arbiter;
    localparam int ADDR_W    = 15;
    localparam int DATA_W    = 32;
    localparam int BURST_MAX = 4;

    logic clk = 1'b0;
    logic reset_n;
    logic freeze;
    always #5 clk = ~clk;

    onchip_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    onchip_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_MAX(BURST_MAX)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .freeze  (freeze),
        .bus     (bus)
    );

    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old_w;
        for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
        return r;
    endfunction

    // Single-port synchronous RAM with a side port for preloading.
    logic [31:0] ram [0:32767];
    logic [31:0] ram_q;
    logic        pre_en;
    logic [14:0] pre_addr;
    logic [31:0] pre_data;
    always @(posedge clk) begin
        if (pre_en) ram[pre_addr] <= pre_data;
        else if (bus.mem_chipselect && bus.mem_write)
            ram[bus.mem_address] <= merge(ram[bus.mem_address], bus.mem_writedata, bus.mem_byteenable);
        else if (bus.mem_chipselect) ram_q <= ram[bus.mem_address];
    end
    assign bus.mem_readdata = ram_q;

    int n_vec = 0;
    int n_bad = 0;
    int m_owner;   // 0 = A, 1 = B
    int m_streak;
    logic [31:0] ref_mem [0:32767];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic set_idle();
        bus.a_read = 1'b0; bus.a_write = 1'b0; bus.a_address = 15'h0; bus.a_byteenable = 4'h0;
        bus.a_writedata = 32'h0;
        bus.b_read = 1'b0; bus.b_write = 1'b0; bus.b_address = 15'h0; bus.b_byteenable = 4'h0;
        bus.b_writedata = 32'h0;
        freeze = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        set_idle();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_rdv_a", 64'(bus.a_readdatavalid), 64'd0);
        chk("reset_rdv_b", 64'(bus.b_readdatavalid), 64'd0);
        chk("reset_cs", 64'(bus.mem_chipselect), 64'd0);
        reset_n  = 1'b1;
        m_owner  = 0;
        m_streak = 0;
    endtask

    task automatic preload(input logic [14:0] a, input logic [31:0] d);
        set_idle();
        pre_en = 1'b1; pre_addr = a; pre_data = d;
        ref_mem[a] = d;
        @(posedge clk);
        #1;
        pre_en = 1'b0;
    endtask

    // One bus cycle: drive, predict from the arbitration rules, check, advance.
    task automatic cyc(input bit frz, input bit ar, input bit aw, input logic [14:0] aad,
                       input logic [3:0] abe, input logic [31:0] awd,
                       input bit br, input bit bw, input logic [14:0] bad,
                       input logic [3:0] bbe, input logic [31:0] bwd);
        int g;
        bit ra, rb, wsel, e_rda, e_rdb;
        logic [14:0] e_addr;
        logic [3:0]  e_be;
        logic [31:0] e_wd, e_data;
        freeze = frz;
        bus.a_read = ar; bus.a_write = aw; bus.a_address = aad; bus.a_byteenable = abe;
        bus.a_writedata = awd;
        bus.b_read = br; bus.b_write = bw; bus.b_address = bad; bus.b_byteenable = bbe;
        bus.b_writedata = bwd;
        ra = ar | aw;
        rb = br | bw;
        if (frz) g = 0;
        else if (ra && rb) g = (m_streak < BURST_MAX) ? m_owner + 1 : 2 - m_owner;
        else if (ra) g = 1;
        else if (rb) g = 2;
        else g = 0;
        if (!frz) begin
            if (g == 0) m_streak = 0;
            else if (g == m_owner + 1) m_streak = (m_streak < BURST_MAX) ? m_streak + 1 : BURST_MAX;
            else begin m_owner = g - 1; m_streak = 1; end
        end
        wsel   = (g == 1) ? aw : (g == 2) ? bw : 1'b0;
        e_addr = (g == 1) ? aad : (g == 2) ? bad : 15'h0;
        e_wd   = (g == 1) ? awd : (g == 2) ? bwd : 32'h0;
        e_be   = (g == 0) ? 4'h0 : (!wsel) ? 4'hF : (g == 1) ? abe : bbe;
        e_rda  = (g == 1) && ar && !aw;
        e_rdb  = (g == 2) && br && !bw;
        e_data = ref_mem[e_addr];
        if (g != 0 && wsel) ref_mem[e_addr] = merge(ref_mem[e_addr], e_wd, e_be);
        #3;
        chk("cs", 64'(bus.mem_chipselect), 64'(g != 0));
        chk("mem_write", 64'(bus.mem_write), 64'(g != 0 && wsel));
        chk("mem_addr", 64'(bus.mem_address), 64'(e_addr));
        chk("mem_be", 64'(bus.mem_byteenable), 64'(e_be));
        chk("mem_wdata", 64'(bus.mem_writedata), 64'(e_wd));
        chk("wait_a", 64'(bus.a_waitrequest), 64'(ra && g != 1));
        chk("wait_b", 64'(bus.b_waitrequest), 64'(rb && g != 2));
        @(posedge clk);
        #1;
        chk("rdv_a", 64'(bus.a_readdatavalid), 64'(e_rda));
        chk("rdv_b", 64'(bus.b_readdatavalid), 64'(e_rdb));
        if (e_rda) chk("rdata_a", 64'(bus.a_readdata), 64'(e_data));
        if (e_rdb) chk("rdata_b", 64'(bus.b_readdata), 64'(e_data));
    endtask

    typedef struct {
        bit frz, ar, aw, br, bw;
        bit [1:0] gnt;
        bit wa, wb, we;
    } vec_t;

    vec_t tbl [19];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [14:0] ea;
        logic [3:0]  eb;
        logic [31:0] ew;
        pre_en = 1'b0; pre_addr = 15'h0; pre_data = 32'h0;
        reset_n = 1'b0;
        set_idle();
        //           frz   ar    aw    br    bw    gnt   wa    wb    we
        tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd1, 1'b0, 1'b1, 1'b0};
        tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd1, 1'b0, 1'b1, 1'b0};
        tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd1, 1'b0, 1'b1, 1'b0};
        tbl[5]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd2, 1'b1, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd2, 1'b1, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd2, 1'b1, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd2, 1'b1, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd1, 1'b0, 1'b1, 1'b0};
        tbl[10] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0};
        tbl[11] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 1'b1};
        tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0};
        tbl[13] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 1'b1, 1'b0};
        tbl[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 1'b1};
        tbl[15] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'd2, 1'b1, 1'b0, 1'b0};
        tbl[16] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 1'b1};
        tbl[17] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0};
        tbl[18] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0};

        do_reset();
        for (int i = 0; i < 19; i++) begin
            freeze = tbl[i].frz;
            bus.a_read = tbl[i].ar; bus.a_write = tbl[i].aw; bus.a_address = 15'h0AAA;
            bus.a_byteenable = 4'h3; bus.a_writedata = 32'hAAAA5555;
            bus.b_read = tbl[i].br; bus.b_write = tbl[i].bw; bus.b_address = 15'h0BBB;
            bus.b_byteenable = 4'hC; bus.b_writedata = 32'h5555AAAA;
            ea = (tbl[i].gnt == 2'd1) ? 15'h0AAA : (tbl[i].gnt == 2'd2) ? 15'h0BBB : 15'h0;
            ew = (tbl[i].gnt == 2'd1) ? 32'hAAAA5555 : (tbl[i].gnt == 2'd2) ? 32'h5555AAAA : 32'h0;
            eb = (tbl[i].gnt == 2'd0) ? 4'h0 : (!tbl[i].we) ? 4'hF : (tbl[i].gnt == 2'd1) ? 4'h3 : 4'hC;
            #3;
            chk($sformatf("tbl%0d_cs", i), 64'(bus.mem_chipselect), 64'(tbl[i].gnt != 2'd0));
            chk($sformatf("tbl%0d_wa", i), 64'(bus.a_waitrequest), 64'(tbl[i].wa));
            chk($sformatf("tbl%0d_wb", i), 64'(bus.b_waitrequest), 64'(tbl[i].wb));
            chk($sformatf("tbl%0d_we", i), 64'(bus.mem_write), 64'(tbl[i].we));
            chk($sformatf("tbl%0d_addr", i), 64'(bus.mem_address), 64'(ea));
            chk($sformatf("tbl%0d_be", i), 64'(bus.mem_byteenable), 64'(eb));
            chk($sformatf("tbl%0d_wd", i), 64'(bus.mem_writedata), 64'(ew));
            @(posedge clk);
            #1;
        end

        // Back-to-back reads by A alone.
        do_reset();
        for (int i = 0; i < 4; i++) preload(15'h0010 + 15'(i), 32'h1000_0010 + 32'(i));
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 1'b1, 1'b0, 15'h0010 + 15'(i), 4'h0, 32'h0, 1'b0, 1'b0, 15'h0, 4'h0, 32'h0);
            chk("t1_data", 64'(bus.a_readdata), 64'(32'h1000_0010 + 32'(i)));
        end

        // Continuous contention from reset: A x4, B x4, A x4.
        do_reset();
        for (int i = 0; i < 12; i++) begin
            cyc(1'b0, 1'b1, 1'b0, 15'h0010 + 15'(i % 4), 4'h0, 32'h0,
                1'b1, 1'b0, 15'h0013 - 15'(i % 4), 4'h0, 32'h0);
            chk("t2_order", 64'(bus.a_readdatavalid), 64'(((i / 4) % 2) == 0));
        end

        // Partial write by A then read by B.
        preload(15'h7FFF, 32'h12345678);
        cyc(1'b0, 1'b0, 1'b1, 15'h7FFF, 4'h3, 32'hDEADBEEF, 1'b0, 1'b0, 15'h0, 4'h0, 32'h0);
        cyc(1'b0, 1'b0, 1'b0, 15'h0, 4'h0, 32'h0, 1'b1, 1'b0, 15'h7FFF, 4'h0, 32'h0);
        chk("t3_data", 64'(bus.b_readdata), 64'(32'h1234BEEF));

        // Freeze right after an A read.
        cyc(1'b0, 1'b1, 1'b0, 15'h0011, 4'h0, 32'h0, 1'b0, 1'b0, 15'h0, 4'h0, 32'h0);
        chk("t4_rdv_in_flight", 64'(bus.a_readdatavalid), 64'd1);
        cyc(1'b1, 1'b1, 1'b0, 15'h0012, 4'h0, 32'h0, 1'b1, 1'b0, 15'h0013, 4'h0, 32'h0);

        // Reset arriving while an A read is in flight.
        set_idle();
        bus.a_read = 1'b1; bus.a_address = 15'h0010;
        @(posedge clk);
        #0.2;
        reset_n = 1'b0;
        #1;
        chk("t5_rdv_dropped", 64'(bus.a_readdatavalid), 64'd0);
        chk("t5_cs_in_reset", 64'(bus.mem_chipselect), 64'd0);
        chk("t5_wait_in_reset", 64'(bus.a_waitrequest), 64'd1);
        @(posedge clk);
        #1;
        chk("t5_rdv_hold", 64'(bus.a_readdatavalid), 64'd0);
        set_idle();
        reset_n = 1'b1;
        m_owner = 0;
        m_streak = 0;
        cyc(1'b0, 1'b0, 1'b0, 15'h0, 4'h0, 32'h0, 1'b0, 1'b0, 15'h0, 4'h0, 32'h0);
        cyc(1'b0, 1'b1, 1'b0, 15'h0010, 4'h0, 32'h0, 1'b1, 1'b0, 15'h0011, 4'h0, 32'h0);
        chk("t5_owner_a", 64'(bus.a_readdatavalid), 64'd1);
        do_reset();
        cyc(1'b0, 1'b0, 1'b0, 15'h0, 4'h0, 32'h0, 1'b1, 1'b0, 15'h0012, 4'h0, 32'h0);
        chk("t5_b_alone", 64'(bus.b_readdatavalid), 64'd1);

        // Read and write together: the write wins.
        cyc(1'b0, 1'b1, 1'b1, 15'h0100, 4'hF, 32'hCAFEF00D, 1'b0, 1'b0, 15'h0, 4'h0, 32'h0);
        cyc(1'b0, 1'b1, 1'b0, 15'h0100, 4'h0, 32'h0, 1'b0, 1'b0, 15'h0, 4'h0, 32'h0);
        chk("t6_data", 64'(bus.a_readdata), 64'(32'hCAFEF00D));

        // Random traffic over a small address window.
        for (int i = 0; i < 16; i++) preload(15'h0020 + 15'(i), $urandom);
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom % 8) == 0,
                $urandom_range(0, 1) == 1, ($urandom % 4) == 0, 15'h0020 + 15'($urandom % 16),
                4'($urandom), $urandom,
                $urandom_range(0, 1) == 1, ($urandom % 4) == 0, 15'h0020 + 15'($urandom % 16),
                4'($urandom), $urandom);
        end

        set_idle();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
